polar_enc_loader: RTL and testbench
===================================

// Module: polar_enc_loader
// PURPOSE
//  Upstream feeder of POLAR_ENC. Collects K info bits from a valid/ready word stream and places them
//  on the non-frozen positions of the 384-bit u-vector; frozen positions are forced to 0.
//  Pulses the encoder start, then holds off the next block until the encoder reports done.
//  K = 96 at rate 1/4 (polar_rate_sel=0) and K = 144 at rate 3/8 (polar_rate_sel=1).
// PARAMETERS
//  N_BITS   384  u-vector length; equals the encoder input width
//  IN_W     8    input word width; must divide 96 and 144
// PORTS
//  clk              in   1       single clock, 64 MHz
//  rst              in   1       synchronous, active-high reset
//  s_valid          in   1       input word valid
//  s_ready          out  1       input word accepted when s_valid & s_ready
//  s_data           in   IN_W    info bits, bit 0 first
//  s_last           in   1       marks the final word of a block
//  rate_sel         in   1       0: 1/4, 1: 3/8; sampled with the block's first word
//  enc_start        out  1       one-cycle start pulse to the encoder
//  enc_rate_sel     out  1       latched rate to the encoder
//  enc_data         out  N_BITS  u-vector; bit i is u[i]
//  enc_done         in   1       encoder done pulse
//  busy             out  1       high in any state other than IDLE
//  frame_err        out  1       one-cycle pulse on a framing error
// BEHAVIOUR
//  Reset: every output is 0, FSM = IDLE, and all counters and buffers are cleared.
//  FSM states: IDLE -> FILL -> LAUNCH -> WAIT_DONE -> IDLE.
//  IDLE: s_ready=1. On the first accepted word: latch rate_sel into enc_rate_sel, load the word
//   into the bit buffer (cnt=IN_W), set pos=0 and wcnt=1, then go to FILL.
//  FILL: one u-position per cycle, in ascending pos order.
//   - FROZEN[rate][pos]=1: write enc_data[pos]=0 and advance pos.
//   - FROZEN[rate][pos]=0 and cnt>0: write the buffer LSB to enc_data[pos], shift the buffer,
//     decrement cnt, advance pos.
//   - FROZEN[rate][pos]=0 and cnt=0: stall; pos holds.
//   s_ready = (cnt==0) or (cnt==1 and an info bit is consumed this cycle).
//   An accepted word reloads the buffer and increments wcnt.
//   After pos=N_BITS-1 is written, go to LAUNCH.
//  Framing check, against K/IN_W words (12 or 18):
//   - s_last on word wcnt < K/IN_W, or no s_last on word K/IN_W: pulse frame_err, drop the block,
//     clear enc_data, go to IDLE.
//   - On the early-last case the block ends there. On the missing-last case, discard words up to
//     and including the next s_last, with s_ready=1.
//  LAUNCH: enc_start=1 for exactly one cycle; enc_data and enc_rate_sel are already stable; go to WAIT_DONE.
//  WAIT_DONE: s_ready=0; enc_data is held. On enc_done go to IDLE; the next block's first word
//   can be accepted the following cycle.
//   The encoder reloads its pipeline on start, so a second start before done is forbidden by design.
//  enc_done outside WAIT_DONE is ignored.
//  Latency with no stalls: enc_start pulses N_BITS+1 cycles after the first word is accepted.
//  rate_sel changes mid-block have no effect.
//  rst mid-block: immediate return to IDLE with no enc_start, and the block is lost.
// STRUCTURE
//  polar_pkg: N_BITS, K_R14=96, K_R38=144, FROZEN_R14 and FROZEN_R38 384-bit masks (popcount of 0s = K),
//   FSM state encoding.
//  One sub-module, polar_bit_unpacker: IN_W buffer with cnt, load, and shift-out;
//   the FSM and position counter stay in the top.
//  The mask lookup is a mux on pos; no RAM.
// TESTING
//  1. Reset: drive rst for 2 cycles -> all outputs 0, FSM IDLE; s_ready=1 the cycle after rst drops.
//  2. Rate 1/4: 12 words of 8'hFF, last on the 12th, no stalls -> enc_start exactly 385 cycles after
//     word 0; enc_data == ~FROZEN_R14.
//  3. Rate 3/8: 18 words 8'hA5 with random s_valid gaps -> enc_data matches the reference model;
//     exactly one enc_start; enc_rate_sel=1.
//  4. s_last on word 5 at rate 1/4 -> one frame_err pulse, no enc_start, FSM back in IDLE.
//  5. Two back-to-back blocks with enc_done returned 6 cycles after enc_start -> s_ready=0 during
//     WAIT_DONE; the second block's enc_data is correct; enc_start pulses never overlap.
//  6. rst asserted at pos=200 -> no enc_start; the next block encodes correctly.

Source files
------------

// File: rtl/polar_pkg.sv
// Shared constants, frozen-position masks and FSM encoding for the polar
// encoder feeder.
package polar_pkg;

  localparam int N_BITS = 384;
  localparam int K_R14  = 96;
  localparam int K_R38  = 144;
  localparam int POS_W  = 9;

  // Mask bit = 1 marks a frozen u-position.
  // Rate 1/4 keeps bit 3 of every nibble (96 info positions).
  // Rate 3/8 keeps bits 3, 6 and 7 of every byte (144 info positions).
  // The rate-3/8 info set contains the rate-1/4 info set.
  localparam logic [N_BITS-1:0] FROZEN_R14 = {96{4'h7}};
  localparam logic [N_BITS-1:0] FROZEN_R38 = {48{8'h37}};

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FILL      = 2'd1,
    ST_LAUNCH    = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  // Mux lookup of the frozen flag for one position; no RAM involved.
  function automatic logic is_frozen(input logic rate, input logic [POS_W-1:0] pos);
    return rate ? FROZEN_R38[pos] : FROZEN_R14[pos];
  endfunction

endpackage

// File: rtl/polar_bit_unpacker.sv
// One-word bit buffer: load a word, then hand out its bits LSB first.
// cnt is the number of bits still held.
module polar_bit_unpacker #(
  parameter int IN_W  = 8,
  parameter int CNT_W = $clog2(IN_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [IN_W-1:0]  data,
  output logic             bit_out,
  output logic [CNT_W-1:0] cnt
);

  logic [IN_W-1:0] sreg;

  // Load wins over shift: a reload on the same cycle the final bit is taken
  // replaces the spent word.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= data;
      cnt  <= CNT_W'(IN_W);
    end else if (shift && (cnt != '0)) begin
      sreg <= sreg >> 1;
      cnt  <= cnt - CNT_W'(1);
    end
  end

  assign bit_out = sreg[0];

endmodule

// File: rtl/polar_enc_loader.sv
// Feeder for the polar encoder: gathers K info bits from a valid/ready word
// stream, spreads them over the non-frozen u-positions, pulses enc_start and
// waits for enc_done before taking the next block.
//
// Handshake: a word transfers on a cycle where s_valid and s_ready are both
// high; s_valid/s_data/s_last/rate_sel must hold until that cycle, and
// s_ready never depends on anything but state and the current cycle.
module polar_enc_loader
  import polar_pkg::*;
#(
  parameter int IN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [IN_W-1:0]   s_data,
  input  logic              s_last,
  input  logic              rate_sel,
  output logic              enc_start,
  output logic              enc_rate_sel,
  output logic [N_BITS-1:0] enc_data,
  input  logic              enc_done,
  output logic              busy,
  output logic              frame_err
);

  localparam int CNT_W      = $clog2(IN_W + 1);
  localparam int WORDS_R14  = K_R14 / IN_W;
  localparam int WORDS_R38  = K_R38 / IN_W;
  localparam int WCNT_W     = $clog2(WORDS_R38 + 1);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(N_BITS - 1);

  state_t              state_q, state_d;
  logic [POS_W-1:0]    pos_q;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_inc, k_words;
  logic                discard_q;
  logic [CNT_W-1:0]    cnt;
  logic                bit_out;
  logic                ready_c, acc, load, consume, advance, frozen;
  logic                start_block, err_early, err_missing;

  polar_bit_unpacker #(.IN_W(IN_W), .CNT_W(CNT_W)) u_unpacker (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .shift   (consume),
    .data    (s_data),
    .bit_out (bit_out),
    .cnt     (cnt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state, handshake and per-cycle fill decisions.
  always_comb begin
    state_d     = state_q;
    ready_c     = 1'b0;
    acc         = 1'b0;
    load        = 1'b0;
    consume     = 1'b0;
    advance     = 1'b0;
    start_block = 1'b0;
    err_early   = 1'b0;
    err_missing = 1'b0;
    enc_start   = 1'b0;
    k_words     = enc_rate_sel ? WCNT_W'(WORDS_R38) : WCNT_W'(WORDS_R14);
    frozen      = is_frozen(enc_rate_sel, pos_q);
    wcnt_inc    = wcnt_q + WCNT_W'(1);
    case (state_q)
      ST_IDLE: begin
        ready_c = 1'b1;
        acc     = s_valid & ~rst;
        // While discarding, words are swallowed until the closing s_last.
        if (acc && !discard_q) begin
          if (s_last) begin
            // A block is always longer than one word, so this is early-last.
            err_early = 1'b1;
          end else begin
            load        = 1'b1;
            start_block = 1'b1;
            state_d     = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        consume = !frozen && (cnt != '0);
        advance = frozen || (cnt != '0);
        // Ask for a word only when the buffer runs dry and more are due.
        ready_c = (wcnt_q < k_words) &&
                  ((cnt == '0) || ((cnt == CNT_W'(1)) && consume));
        acc     = s_valid & ready_c & ~rst;
        if (acc && s_last && (wcnt_inc < k_words)) begin
          err_early = 1'b1;
          state_d   = ST_IDLE;
        end else if (acc && !s_last && (wcnt_inc == k_words)) begin
          err_missing = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          load = acc;
          if (advance && (pos_q == LAST_POS)) state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        enc_start = 1'b1;
        state_d   = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (enc_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s_ready = ready_c & ~rst;
  assign busy    = (state_q != ST_IDLE);

  // Position/word counters, u-vector writes, rate latch and framing flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q        <= '0;
      wcnt_q       <= '0;
      enc_rate_sel <= 1'b0;
      enc_data     <= '0;
      discard_q    <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      frame_err <= err_early | err_missing;
      if (start_block) begin
        enc_rate_sel <= rate_sel;
        pos_q        <= '0;
        wcnt_q       <= WCNT_W'(1);
      end
      if (state_q == ST_FILL) begin
        if (load) wcnt_q <= wcnt_inc;
        if (advance) begin
          enc_data[pos_q] <= consume ? bit_out : 1'b0;
          pos_q           <= pos_q + POS_W'(1);
        end
      end
      // A dropped block leaves no partial u-vector behind.
      if (err_early || err_missing) enc_data <= '0;
      if (err_missing) discard_q <= 1'b1;
      else if ((state_q == ST_IDLE) && discard_q && acc && s_last) discard_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_polar_enc_loader.sv
// Directed bench for polar_enc_loader with a u-vector scoreboard.
module tb_polar_enc_loader;

  localparam int NB = 384;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          rate_sel = 1'b0;
  logic          enc_done = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          s_ready, enc_start, enc_rate_sel, busy, frame_err;
  logic [NB-1:0] enc_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int first_acc = 0;
  int start_cnt = 0;
  int last_start_cyc = 0;
  int err_cnt = 0;
  bit prev_start = 1'b0;

  logic [NB-1:0] exp_q[$];
  logic          exp_rate_q[$];

  polar_enc_loader #(.IN_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .rate_sel     (rate_sel),
    .enc_start    (enc_start),
    .enc_rate_sel (enc_rate_sel),
    .enc_data     (enc_data),
    .enc_done     (enc_done),
    .busy         (busy),
    .frame_err    (frame_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit tb_frozen(input logic r, input int p);
    if (!r) return (p % 4) != 3;
    return !(((p % 4) == 3) || ((p % 8) == 6));
  endfunction

  function automatic logic [NB-1:0] model_u(input logic r, input logic [255:0] s);
    logic [NB-1:0] u;
    int k;
    u = '0;
    k = 0;
    for (int p = 0; p < NB; p++) begin
      if (!tb_frozen(r, p)) begin
        u[p] = s[k];
        k++;
      end
    end
    return u;
  endfunction

  function automatic logic [NB-1:0] info_mask(input logic r);
    logic [NB-1:0] m;
    for (int p = 0; p < NB; p++) m[p] = !tb_frozen(r, p);
    return m;
  endfunction

  task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [W-1:0] d, input logic last, input logic r);
    int guard;
    guard = 0;
    @(negedge clk); #1;
    s_valid  = 1'b1;
    s_data   = d;
    s_last   = last;
    rate_sel = r;
    #1;
    while (s_ready !== 1'b1 && guard < 3000) begin
      @(negedge clk); #2;
      guard++;
    end
    check("handshake_timeout", NB'(guard < 3000), NB'(1));
    acc_cyc = cyc;
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // last_at < 0 means no word carries s_last.
  task automatic send_block(input logic r, input int nwords, input int last_at,
                            input bit rand_data, input logic [W-1:0] fixed,
                            input int max_gap, input bit push);
    logic [255:0] stream;
    logic [W-1:0] d;
    logic         rr;
    stream = '0;
    for (int i = 0; i < nwords; i++) begin
      d  = rand_data ? W'($urandom_range(0, 255)) : fixed;
      rr = (i == 0) ? r : 1'($urandom_range(0, 1));
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_word(d, (i == last_at), rr);
      if (i == 0) first_acc = acc_cyc;
      stream[i*W +: W] = d;
    end
    if (push) begin
      exp_q.push_back(model_u(r, stream));
      exp_rate_q.push_back(r);
    end
  endtask

  task automatic wait_starts(input int n);
    int g;
    g = 0;
    while (start_cnt < n && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("start_count", NB'(start_cnt), NB'(n));
    g = 0;
    while (busy !== 1'b0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("back_to_idle", NB'(busy), '0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) err_cnt++;
      if (enc_start) begin
        start_cnt++;
        last_start_cyc = cyc;
        check("start_no_overlap", NB'(prev_start), '0);
        check("start_expected", NB'(exp_q.size() != 0), NB'(1));
        if (exp_q.size() != 0) begin
          check("enc_data", enc_data, exp_q.pop_front());
          check("enc_rate_sel", NB'(enc_rate_sel), NB'(exp_rate_q.pop_front()));
        end
      end
      prev_start = enc_start;
    end
  end

  // Encoder stand-in: done 6 cycles after each start.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && enc_start) begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          check("wait_ready_low", NB'(s_ready), '0);
          check("wait_busy", NB'(busy), NB'(1));
        end
        enc_done = 1'b1;
        @(negedge clk);
        enc_done = 1'b0;
        check("idle_after_done", NB'(busy), '0);
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int s0, e0, c0;

    // Reset: held two cycles, all outputs low.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", NB'(s_ready), '0);
    check("rst_enc_start", NB'(enc_start), '0);
    check("rst_enc_rate_sel", NB'(enc_rate_sel), '0);
    check("rst_enc_data", enc_data, '0);
    check("rst_busy", NB'(busy), '0);
    check("rst_frame_err", NB'(frame_err), '0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", NB'(s_ready), NB'(1));

    // Rate 1/4, all-ones data, no gaps: latency and info-position map.
    send_block(1'b0, 12, 11, 1'b0, 8'hFF, 0, 1'b1);
    wait_starts(1);
    check("latency_r14", NB'(last_start_cyc - first_acc), NB'(385));
    check("r14_info_mask", enc_data, info_mask(1'b0));

    // Early s_last on word 5.
    s0 = start_cnt;
    e0 = err_cnt;
    send_block(1'b0, 5, 4, 1'b1, 8'h00, 0, 1'b0);
    repeat (3) @(negedge clk);
    check("early_err_pulses", NB'(err_cnt), NB'(e0 + 1));
    check("early_no_start", NB'(start_cnt), NB'(s0));
    check("early_idle", NB'(busy), '0);
    check("early_cleared", enc_data, '0);

    // Missing s_last on word 12, then two words to discard (last on the 2nd).
    e0 = err_cnt;
    send_block(1'b0, 12, -1, 1'b1, 8'h00, 0, 1'b0);
    send_block(1'b0, 2, 1, 1'b1, 8'h00, 0, 1'b0);
    repeat (3) @(negedge clk);
    check("missing_err_pulses", NB'(err_cnt), NB'(e0 + 1));
    check("missing_no_start", NB'(start_cnt), NB'(s0));
    check("missing_idle", NB'(busy), '0);

    // Rate 3/8, 8'hA5 words with random valid gaps and mid-block rate_sel noise.
    send_block(1'b1, 18, 17, 1'b0, 8'hA5, 3, 1'b1);
    wait_starts(s0 + 1);

    // Two back-to-back blocks of random data.
    s0 = start_cnt;
    send_block(1'b0, 12, 11, 1'b1, 8'h00, 0, 1'b1);
    send_block(1'b1, 18, 17, 1'b1, 8'h00, 0, 1'b1);
    wait_starts(s0 + 2);

    // Reset while position 200 is being written.
    s0 = start_cnt;
    for (int i = 0; i < 7; i++) begin
      send_word(W'($urandom_range(0, 255)), 1'b0, 1'b0);
      if (i == 0) c0 = acc_cyc;
    end
    while (cyc < c0 + 201) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle", NB'(busy), '0);
    check("midrst_data", enc_data, '0);
    check("midrst_ready", NB'(s_ready), NB'(1));
    check("midrst_no_start", NB'(start_cnt), NB'(s0));
    send_block(1'b0, 12, 11, 1'b1, 8'h00, 2, 1'b1);
    wait_starts(s0 + 1);

    check("scoreboard_empty", NB'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
